ext_bus_ctrl: RTL

//   External-bus cycle engine between the registered 6502 bus (cpu_addr/cpu_dout/cpu_we)
//   and the physical data_io / address / strobe pins. Runs a SETUP/STROBE/HOLD access with

---
 rtl/ext_bus_ctrl.sv | 76 +++++++
 1 files changed

// File: rtl/ext_bus_ctrl.sv
// ext_bus_ctrl: external bus cycle engine (SETUP/STROBE/HOLD) with wait states
// that stretches the CPU clock-enable until the access has completed.
module ext_bus_ctrl #(
  parameter int WAIT_STATES = 2,
  parameter int ADDR_BITS = 16
) (
  input  logic                 clk,
  input  logic                 resb,
  input  logic                 clken_in,
  output logic                 cpu_clken,
  input  logic                 bus_e,
  input  logic [ADDR_BITS-1:0] cpu_addr,
  input  logic [7:0]           cpu_dout,
  input  logic                 cpu_we,
  output logic [7:0]           ext_din,
  output logic [ADDR_BITS-1:0] ext_addr,
  output logic [7:0]           ext_dout,
  output logic                 ext_doe,
  input  logic [7:0]           ext_din_pin,
  output logic                 ext_csb,
  output logic                 ext_oeb,
  output logic                 ext_web,
  output logic                 ext_rwb,
  output logic                 busy
);
  localparam int CW = ($clog2(WAIT_STATES + 1) > 1) ? $clog2(WAIT_STATES + 1) : 1;
  typedef enum logic [1:0] {IDLE, SETUP, STROBE, HOLD} state_t;
  state_t state, state_nx;
  logic [CW-1:0] cnt;
  logic done, start;
  // The core's own reset sequence needs raw enables, so reset bypasses the stretch.
  assign cpu_clken = clken_in & (~resb | ~(bus_e & ~done));
  assign start = bus_e & ~done & ~cpu_clken;
  always_ff @(posedge clk)
    state <= !resb ? IDLE : state_nx;
  always_comb begin
    state_nx = state;
    busy = state != IDLE;
    ext_csb = state == IDLE;
    ext_oeb = 1'b1;
    ext_web = 1'b1;
    ext_doe = busy & ~ext_rwb;
    case (state)
      IDLE:    state_nx = start ? SETUP : IDLE;
      SETUP:   state_nx = STROBE;
      STROBE: begin
        state_nx = (cnt == '0) ? HOLD : STROBE;
        ext_oeb = ~ext_rwb;
        ext_web = ext_rwb;
      end
      default: state_nx = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (!resb) begin
      done <= 1'b0;
      ext_addr <= '0;
      ext_dout <= '0;
      ext_din <= '0;
      ext_rwb <= 1'b1;
      cnt <= '0;
    end else begin
      if (state == HOLD) done <= 1'b1;
      else if (cpu_clken) done <= 1'b0;
      if (state == IDLE && start) begin
        ext_addr <= cpu_addr;
        ext_dout <= cpu_dout;
        ext_rwb <= ~cpu_we;
      end
      if (state == SETUP) cnt <= CW'(WAIT_STATES);
      else if (state == STROBE && cnt != '0) cnt <= cnt - CW'(1);
      // Read data is sampled at the end of the final strobe cycle.
      if (state == STROBE && cnt == '0 && ext_rwb) ext_din <= ext_din_pin;
    end
  end
endmodule
